edge_event_arbiter: RTL and testbench

Multi-channel rising-edge event collector and round-robin scheduler. Each channel detects 0->1 transitions on its level input and latches a pending event. One shared event port presents pending events to a single consumer, one at a time, over a valid/ready handshake. It sits between raw level sources (buttons, status lines) and a single event-processing FSM.

---
 rtl/edge_event_arbiter.sv | 132 +++++++++++++
 tb/tb_edge_event_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector with a round-robin valid/ready event port.
// Optional EDGE_ARB_SYNC_EN adds a 2-flop synchronizer per channel ahead of edge detection.
module edge_event_arbiter #(
    parameter  int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] level,
    input  logic            evt_ready,
    input  logic            ovf_clr,
    output logic            evt_valid,
    output logic [CH_W-1:0] evt_ch,
    output logic [N_CH-1:0] pend,
    output logic [N_CH-1:0] ovf,
    output logic            busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t          state;
    logic [N_CH-1:0] level_s;
    logic [N_CH-1:0] level_d;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] hs_vec;
    logic [N_CH-1:0] ovf_set;
    logic [CH_W-1:0] last_grant;
    logic [CH_W-1:0] next_ch;
    logic            hs;
    logic            found;
    int              idx;

`ifdef EDGE_ARB_SYNC_EN
    logic [N_CH-1:0] sync_q1;
    logic [N_CH-1:0] sync_q2;

    // level may be asynchronous here; only sync_q2 is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
            sync_q1 <= level;
            sync_q2 <= sync_q1;
        end
    end

    assign level_s = sync_q2;
`else
    assign level_s = level;
`endif

    assign rise    = level_s & ~level_d;
    assign hs      = (state == OFFER) && evt_ready;
    assign ovf_set = rise & pend & ~hs_vec;

    always_comb begin
        // NOTE: default assignment first so no path leaves hs_vec unassigned (no latch).
        hs_vec = '0;
        if (hs) begin
            hs_vec[evt_ch] = 1'b1;
        end
    end

    // Round-robin: first pending channel after last_grant, wrapping to 0.
    always_comb begin
        next_ch = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(last_grant) + k) % N_CH;
            if (!found && pend[idx]) begin
                next_ch = CH_W'(idx);
                found   = 1'b1;
            end
        end
    end

    // A rise beats a same-cycle handshake, so that event is re-latched rather than lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= '0;
            pend    <= '0;
            ovf     <= '0;
        end else begin
            level_d <= level_s;
            pend    <= rise | (pend & ~hs_vec);
            if (ovf_clr) begin
                ovf <= ovf_set;
            end else begin
                ovf <= ovf | ovf_set;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            evt_valid  <= 1'b0;
            evt_ch     <= '0;
            last_grant <= CH_W'(N_CH - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|pend) begin
                        evt_ch    <= next_ch;
                        evt_valid <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (evt_ready) begin
                        last_grant <= evt_ch;
                        evt_valid  <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    evt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (|pend) | evt_valid;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus random traffic against a behavioural model.
// Follows EDGE_ARB_SYNC_EN when defined (level path delayed by two cycles).
module tb_edge_event_arbiter;

    localparam int N  = 4;
    localparam int CW = $clog2(N);
`ifdef EDGE_ARB_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic [N-1:0]  level     = '0;
    logic          evt_ready = 1'b0;
    logic          ovf_clr   = 1'b0;
    logic          evt_valid;
    logic [CW-1:0] evt_ch;
    logic [N-1:0]  pend;
    logic [N-1:0]  ovf;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    edge_event_arbiter #(.N_CH(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .level     (level),
        .evt_ready (evt_ready),
        .ovf_clr   (ovf_clr),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .pend      (pend),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_pend[N];
    bit m_ovf[N];
    bit m_prev[N];
    bit m_s1[N];
    bit m_s2[N];
    bit m_valid;
    int m_ch;
    int m_last;

    function automatic logic [N-1:0] pack(input bit a[N]);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_ovf[i]  = 0;
            m_prev[i] = 0;
            m_s1[i]   = 0;
            m_s2[i]   = 0;
        end
        m_valid = 0;
        m_ch    = 0;
        m_last  = N - 1;
    endtask

    task automatic model_step();
        bit lv[N];
        bit seen_pend[N];
        int hs_ch;
        for (int i = 0; i < N; i++) begin
`ifdef EDGE_ARB_SYNC_EN
            lv[i]   = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = level[i];
`else
            lv[i] = level[i];
`endif
            seen_pend[i] = m_pend[i];
        end
        hs_ch = (m_valid && evt_ready) ? m_ch : -1;
        if (m_valid) begin
            if (evt_ready) begin
                m_last  = m_ch;
                m_valid = 0;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (seen_pend[(m_last + k) % N]) begin
                    m_ch    = (m_last + k) % N;
                    m_valid = 1;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            bit set_ovf;
            set_ovf = 0;
            if (lv[i] && !m_prev[i]) begin
                if (m_pend[i] && hs_ch != i) set_ovf = 1;
                m_pend[i] = 1;
            end else if (hs_ch == i) begin
                m_pend[i] = 0;
            end
            m_ovf[i]  = ovf_clr ? set_ovf : (m_ovf[i] | set_ovf);
            m_prev[i] = lv[i];
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Single compare process, every falling edge.
    always @(negedge clk) begin
        logic [N-1:0] mp;
        mp = pack(m_pend);
        check("evt_valid", evt_valid, m_valid);
        if (m_valid) check("evt_ch", evt_ch, m_ch);
        check("pend", pend, mp);
        check("ovf", ovf, pack(m_ovf));
        check("busy", busy, (|mp) | m_valid);
    end

    // ---------------- directed helpers ----------------
    task automatic reset_dut();
        @(negedge clk);
        #2 rst_n = 1'b0;
        level     = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_grant(output int ch, output time t);
        int w;
        w = 0;
        @(negedge clk);
        while (!evt_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!evt_valid) check("grant_timeout", 32'(evt_valid), 32'd1);
        ch = int'(evt_ch);
        t  = $time;
    endtask

    initial begin
        int  ch;
        int  lat;
        time t0;
        time t1;
        model_reset();

        // Scenario 1: single rise, latency and handshake.
        reset_dut();
        check("rst_pend", pend, 4'b0000);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_ovf", ovf, 4'b0000);
        check("rst_busy", busy, 1'b0);
        level[2] = 1'b1;
        lat = 0;
        while (!evt_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("s1_latency", lat, 2 + SL);
        check("s1_ch", evt_ch, 2);
        check("s1_pend", pend, 4'b0100);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check("s1_valid_after_hs", evt_valid, 1'b0);
        check("s1_pend_after_hs", pend, 4'b0000);

        // Scenario 2: all channels rise together, ready held high.
        reset_dut();
        level     = 4'b1111;
        evt_ready = 1'b1;
        t0 = 0;
        for (int g = 0; g < N; g++) begin
            wait_grant(ch, t1);
            check("s2_order", ch, g);
            if (g > 0) check("s2_spacing", 32'(t1 - t0), 32'd20);
            t0 = t1;
        end
        check("s2_ovf", ovf, 4'b0000);

        // Scenario 3: fairness after ch1 with pend=1011.
        reset_dut();
        level = 4'b0010;
        wait_grant(ch, t1);
        check("s3_first", ch, 1);
        level = 4'b0000;
        @(negedge clk);
        level = 4'b1011;
        repeat (SL) @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        check("s3_pend", pend, 4'b1011);
        check("s3_idle", evt_valid, 1'b0);
        wait_grant(ch, t1);
        check("s3_g3", ch, 3);
        wait_grant(ch, t1);
        check("s3_g0", ch, 0);
        wait_grant(ch, t1);
        check("s3_g1", ch, 1);

        // Scenario 4: overflow while ch0 is offered and stalled.
        reset_dut();
        level = 4'b0001;
        wait_grant(ch, t1);
        check("s4_offer", ch, 0);
        level = 4'b0000;
        @(negedge clk);
        level = 4'b0001;
        repeat (SL + 1) @(negedge clk);
        check("s4_ovf", ovf, 4'b0001);
        check("s4_pend0", pend[0], 1'b1);
        check("s4_still_offer", evt_valid, 1'b1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("s4_ovf_clr", ovf, 4'b0000);
        level = 4'b0000;
        @(negedge clk);
        level = 4'b0001;
        repeat (SL) @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("s4_set_beats_clr", ovf, 4'b0001);

        // Scenario 5: rise coinciding with handshake, then reset mid-offer.
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        level = 4'b0000;
        @(negedge clk);
        level = 4'b0001;
        repeat (SL) @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check("s5_pend0", pend[0], 1'b1);
        check("s5_ovf0", ovf[0], 1'b0);
        check("s5_idle", evt_valid, 1'b0);
        @(negedge clk);
        check("s5_reoffer", evt_valid, 1'b1);
        check("s5_reoffer_ch", evt_ch, 0);
        level = 4'b1010;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_valid", evt_valid, 1'b0);
        check("s5_rst_pend", pend, 4'b0000);
        check("s5_rst_busy", busy, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) level[i] = ~level[i];
            end
            evt_ready = ($urandom_range(2) != 0);
            ovf_clr   = ($urandom_range(15) == 0);
            if ($urandom_range(499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
